// File: rtl/qos_pkg.sv
// Shared QoS-path definitions: arbiter state encodings and default word geometry,
// common to the VC arbiter, destination demux, FIFOs and init FSM.
package qos_pkg;

    localparam int QOS_BW       = 6;
    localparam int QOS_DEST_BIT = 4;

    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_ACTIVE = 1'b1;

endpackage

// File: rtl/vc_grant_cnt.sv
// Saturating grant counter: counts pops of one virtual channel, sticks at all-ones.
module vc_grant_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC arbiter feeding the destination demux: VC0 has priority, VC1 fills gaps.
// Define VC_ARB_STARVE_EN to bound consecutive VC0 wins to STARVE_MAX while VC1 waits.
module vc_arbiter
    import qos_pkg::*;
#(
    parameter int BW         = QOS_BW,
    parameter int DEST_BIT   = QOS_DEST_BIT,
    parameter int CNT_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arb_en,
    input  logic             VC0_empty,
    input  logic [BW-1:0]    VC0_data_out,
    input  logic             VC1_empty,
    input  logic [BW-1:0]    VC1_data_out,
    input  logic             D0_almost_full,
    input  logic             D1_almost_full,
    output logic             VC0_rd,
    output logic             VC1_rd,
    output logic             arb_valid_out,
    output logic [BW-1:0]    arb_data_out,
    output logic [CNT_W-1:0] vc0_grant_cnt,
    output logic [CNT_W-1:0] vc1_grant_cnt
);

    logic [0:0]    r_state;
    logic          r_valid;
    logic [BW-1:0] r_data;
    logic          w_active;
    logic          w_vc0_blk;
    logic          w_vc1_blk;
    logic          w_vc0_elig;
    logic          w_vc1_elig;
    logic          w_force1;
    logic          w_vc0_gnt;
    logic          w_vc1_gnt;

    // Pops need both the registered ACTIVE state and the live enable.
    assign w_active   = (r_state == ARB_ACTIVE) && arb_en;
    assign w_vc0_blk  = VC0_data_out[DEST_BIT] ? D1_almost_full : D0_almost_full;
    assign w_vc1_blk  = VC1_data_out[DEST_BIT] ? D1_almost_full : D0_almost_full;
    assign w_vc0_elig = w_active && !VC0_empty && !w_vc0_blk;
    assign w_vc1_elig = w_active && !VC1_empty && !w_vc1_blk;

`ifdef VC_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] r_starve;

    assign w_force1 = w_vc1_elig && (r_starve == SW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset)
            r_starve <= '0;
        else if (!w_vc1_elig || w_vc1_gnt)
            r_starve <= '0;
        else if (w_vc0_gnt && (r_starve != SW'(STARVE_MAX)))
            r_starve <= r_starve + SW'(1);
    end
`else
    // Strict priority; STARVE_MAX is referenced only to keep the parameter list uniform.
    assign w_force1 = (STARVE_MAX < 0);
`endif

    assign w_vc0_gnt = !reset && w_vc0_elig && !w_force1;
    assign w_vc1_gnt = !reset && w_vc1_elig && (!w_vc0_elig || w_force1);
    assign VC0_rd    = w_vc0_gnt;
    assign VC1_rd    = w_vc1_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= arb_en ? ARB_ACTIVE : ARB_IDLE;
            r_valid <= w_vc0_gnt || w_vc1_gnt;
            if (w_vc0_gnt)
                r_data <= VC0_data_out;
            else if (w_vc1_gnt)
                r_data <= VC1_data_out;
        end
    end

    assign arb_valid_out = r_valid;
    assign arb_data_out  = r_data;

    vc_grant_cnt #(.CNT_W(CNT_W)) u_vc0_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_vc0_gnt),
        .o_cnt (vc0_grant_cnt)
    );

    vc_grant_cnt #(.CNT_W(CNT_W)) u_vc1_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_vc1_gnt),
        .o_cnt (vc1_grant_cnt)
    );

endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_vc_arbiter;

    localparam int BW = 6;
    localparam int DB = 4;
    localparam int CW = 8;
    localparam int SM = 4;
`ifdef VC_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arb_en = 1'b0;
    logic          VC0_empty = 1'b1;
    logic          VC1_empty = 1'b1;
    logic [BW-1:0] VC0_data_out = '0;
    logic [BW-1:0] VC1_data_out = '0;
    logic          D0_almost_full = 1'b0;
    logic          D1_almost_full = 1'b0;
    logic          VC0_rd, VC1_rd, arb_valid_out;
    logic [BW-1:0] arb_data_out;
    logic [CW-1:0] vc0_grant_cnt, vc1_grant_cnt;

    vc_arbiter #(.BW(BW), .DEST_BIT(DB), .CNT_W(CW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset), .arb_en(arb_en),
        .VC0_empty(VC0_empty), .VC0_data_out(VC0_data_out),
        .VC1_empty(VC1_empty), .VC1_data_out(VC1_data_out),
        .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
        .VC0_rd(VC0_rd), .VC1_rd(VC1_rd),
        .arb_valid_out(arb_valid_out), .arb_data_out(arb_data_out),
        .vc0_grant_cnt(vc0_grant_cnt), .vc1_grant_cnt(vc1_grant_cnt)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int miss = 0;

    // Reference model state: "active" = arb_en was seen high on the previous edge out of reset.
    bit            m_active = 1'b0;
    int            m_starve = 0;
    bit            m_valid = 1'b0;
    logic [BW-1:0] m_data = '0;
    int            m_c0 = 0;
    int            m_c1 = 0;
    bit            g0, g1, m_e1;

    function automatic bit dest_full(input logic [BW-1:0] w);
        logic [BW-1:0] t;
        t = w;
        return (t[DB] == 1'b1) ? D1_almost_full : D0_almost_full;
    endfunction

    function void model_grant();
        bit e0, force1;
        e0     = !reset && m_active && arb_en && !VC0_empty && !dest_full(VC0_data_out);
        m_e1   = !reset && m_active && arb_en && !VC1_empty && !dest_full(VC1_data_out);
        force1 = STARVE && m_e1 && (m_starve == SM);
        g0     = e0 && !force1;
        g1     = m_e1 && !g0;
    endfunction

    task automatic settle();
        #1;
        model_grant();
    endtask

    task automatic tick();
        model_grant();
        @(posedge clk);
        if (reset) begin
            m_active = 1'b0; m_starve = 0; m_valid = 1'b0; m_data = '0; m_c0 = 0; m_c1 = 0;
        end else begin
            if (!m_e1 || g1) m_starve = 0;
            else if (g0) m_starve++;
            m_valid = g0 || g1;
            if (g0) m_data = VC0_data_out;
            else if (g1) m_data = VC1_data_out;
            if (g0 && m_c0 < 255) m_c0++;
            if (g1 && m_c1 < 255) m_c1++;
            m_active = arb_en;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; arb_en = 1'b1;
        VC0_empty = 1'b0; VC0_data_out = 6'h05;
        VC1_empty = 1'b0; VC1_data_out = 6'h13;
        settle();
        vec++;
        if ({VC0_rd, VC1_rd} !== 2'b00) begin
            miss++; $display("FAIL reset_rd got %b%b want 00", VC0_rd, VC1_rd);
        end
        tick(); tick();
        vec++;
        if ({arb_valid_out, arb_data_out, vc0_grant_cnt, vc1_grant_cnt} !== '0) begin
            miss++;
            $display("FAIL reset_state got v=%b d=%h c0=%h c1=%h want all 0",
                     arb_valid_out, arb_data_out, vc0_grant_cnt, vc1_grant_cnt);
        end
    endtask

    task automatic test_vc0_priority();
        reset = 1'b0;
        tick();  // IDLE -> ACTIVE
        settle();
        vec++;
        if ({VC0_rd, VC1_rd} !== 2'b10) begin
            miss++; $display("FAIL prio_rd got %b%b want 10", VC0_rd, VC1_rd);
        end
        tick();
        vec++;
        if ({arb_valid_out, arb_data_out} !== {1'b1, 6'h05}) begin
            miss++; $display("FAIL prio_out got v=%b d=%h want v=1 d=05", arb_valid_out, arb_data_out);
        end
    endtask

    task automatic test_no_hol();
        VC0_data_out = 6'h12; VC1_data_out = 6'h01; D1_almost_full = 1'b1;
        settle();
        vec++;
        if ({VC0_rd, VC1_rd} !== 2'b01) begin
            miss++; $display("FAIL hol_rd got %b%b want 01", VC0_rd, VC1_rd);
        end
        tick();
        vec++;
        if ({arb_valid_out, arb_data_out} !== {1'b1, 6'h01}) begin
            miss++; $display("FAIL hol_out got v=%b d=%h want v=1 d=01", arb_valid_out, arb_data_out);
        end
        D1_almost_full = 1'b0;
    endtask

    task automatic test_dest_full();
        VC0_data_out = 6'h05; VC1_data_out = 6'h01; D0_almost_full = 1'b1;
        settle();
        vec++;
        if ({VC0_rd, VC1_rd} !== 2'b00) begin
            miss++; $display("FAIL full_rd got %b%b want 00", VC0_rd, VC1_rd);
        end
        tick();
        vec++;
        if ({arb_valid_out, arb_data_out} !== {1'b0, 6'h01}) begin
            miss++; $display("FAIL full_out got v=%b d=%h want v=0 d=01 held", arb_valid_out, arb_data_out);
        end
        D0_almost_full = 1'b0;
        settle();
        vec++;
        if ({VC0_rd, VC1_rd} !== 2'b10) begin
            miss++; $display("FAIL release_rd got %b%b want 10", VC0_rd, VC1_rd);
        end
        tick();
    endtask

    task automatic test_starvation();
        bit want1;
        VC1_empty = 1'b1;
        tick();  // VC1 ineligible for a cycle clears any starvation history
        VC1_empty = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            want1 = STARVE && ((i % 5) == 4);
            vec++;
            if ({VC0_rd, VC1_rd} !== {!want1, want1}) begin
                miss++; $display("FAIL starve_%0d got %b%b want %b%b", i, VC0_rd, VC1_rd, !want1, want1);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        VC1_empty = 1'b1; VC0_empty = 1'b0; VC0_data_out = 6'h07;
        for (int i = 0; i < 300; i++) tick();
        vec++;
        if (vc0_grant_cnt !== 8'hFF) begin
            miss++; $display("FAIL sat_cnt got %h want FF", vc0_grant_cnt);
        end
        reset = 1'b1;
        settle();
        vec++;
        if (VC0_rd !== 1'b0) begin
            miss++; $display("FAIL rst_pop_rd got %b want 0", VC0_rd);
        end
        tick();
        vec++;
        if ({arb_valid_out, vc0_grant_cnt, vc1_grant_cnt} !== '0) begin
            miss++;
            $display("FAIL rst_pop_out got v=%b c0=%h c1=%h want 0", arb_valid_out, vc0_grant_cnt, vc1_grant_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 39) == 0);
            arb_en         = ($urandom_range(0, 7) != 0);
            VC0_empty      = ($urandom_range(0, 3) == 0);
            VC1_empty      = ($urandom_range(0, 3) == 0);
            D0_almost_full = ($urandom_range(0, 3) == 0);
            D1_almost_full = ($urandom_range(0, 3) == 0);
            VC0_data_out   = BW'($urandom);
            VC1_data_out   = BW'($urandom);
            settle();
            vec++;
            if ({VC0_rd, VC1_rd} !== {g0, g1}) begin
                miss++; $display("FAIL rand_rd[%0d] got %b%b want %b%b", i, VC0_rd, VC1_rd, g0, g1);
            end
            tick();
            vec++;
            if ({arb_valid_out, arb_data_out, vc0_grant_cnt, vc1_grant_cnt} !==
                {m_valid, m_data, m_c0[7:0], m_c1[7:0]}) begin
                miss++;
                $display("FAIL rand_out[%0d] got v=%b d=%h c0=%h c1=%h want v=%b d=%h c0=%h c1=%h", i,
                         arb_valid_out, arb_data_out, vc0_grant_cnt, vc1_grant_cnt,
                         m_valid, m_data, m_c0[7:0], m_c1[7:0]);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_vc0_priority();
        test_no_hol();
        test_dest_full();
        test_starvation();
        test_saturation();
        reset = 1'b0;
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
